// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational 16-bit ALU between two requesters.
//
// Each accepted operation takes three cycles:
//   IDLE - accept one request
//   EXEC - the ALU evaluates the captured operands
//   RESP - hold the result until the consumer takes it
//
// When both requesters are valid in the same cycle, round-robin arbitration
// picks the one that was not granted last.
//
// The ALU itself lives outside this block. The arbiter drives the ALU
// operand/function inputs from registers and samples the ALU output at the
// end of EXEC.
//
// ALU function select (ALUK):
//   00 ADD    (wraps modulo 2^WIDTH, no carry out)
//   01 AND
//   10 NOT A
//   11 PASS A
//
// Ports:
//   Clk          system clock; all state updates on the rising edge
//   Reset        synchronous, active-high reset
//   reqN_valid   requester N has an operation
//   reqN_ready   requester N operation accepted this cycle (combinational)
//   reqN_a/b     requester N operands
//   reqN_aluk    requester N ALU function select
//   alu_regA/B   registered operands to the ALU
//   alu_ALUK     registered function select to the ALU
//   alu_result   combinational result from the ALU
//   rsp_valid    a response is being held
//   rsp_ready    consumer takes the response
//   rsp_id       requester that owns the response
//   rsp_data     registered ALU result
//   rsp_nzp      one-hot {N,Z,P} condition code of rsp_data
//   busy         high in EXEC or RESP
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_aluk,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_aluk,

    output logic [WIDTH-1:0] alu_regA,
    output logic [WIDTH-1:0] alu_regB,
    output logic [1:0]       alu_ALUK,
    input  logic [WIDTH-1:0] alu_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_nzp,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;

    // Requester granted most recently.
    // Resets to 1 so that requester 0 wins the first tie.
    logic last_grant;

    // Combinational arbitration result for the current IDLE cycle.
    logic grant_any;
    logic grant_id;

    // Condition codes of a result: exactly one of N, Z, P is set.
    function automatic logic [2:0] calc_nzp(input logic [WIDTH-1:0] value);
        if (value == '0) begin
            return 3'b010;
        end else if (value[WIDTH-1]) begin
            return 3'b100;
        end else begin
            return 3'b001;
        end
    endfunction

    // -----------------------------------------------------------------------
    // Arbitration
    //
    // A grant is only offered in IDLE and never while Reset is high, so a
    // request presented together with Reset is never transferred.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_any = 1'b0;
        grant_id  = 1'b0;

        if (!Reset && state == IDLE) begin
            if (req0_valid && req1_valid) begin
                // Tie: alternate away from whoever was served last.
                grant_any = 1'b1;
                grant_id  = ~last_grant;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    // A grant only exists when the requester is valid, so ready implies a
    // transfer in the same cycle.
    assign req0_ready = grant_any & ~grant_id;
    assign req1_ready = grant_any &  grant_id;

    // -----------------------------------------------------------------------
    // Operation sequencer with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // An operation caught in EXEC or RESP is dropped without a
            // response.
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the pre-edge value of every other one.
            state      <= IDLE;
            last_grant <= 1'b1;
            alu_regA   <= '0;
            alu_regB   <= '0;
            alu_ALUK   <= 2'b00;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_nzp    <= 3'b010;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // With no grant, the alu_* registers keep their last
                    // values.
                    if (grant_any) begin
                        if (grant_id) begin
                            alu_regA <= req1_a;
                            alu_regB <= req1_b;
                            alu_ALUK <= req1_aluk;
                        end else begin
                            alu_regA <= req0_a;
                            alu_regB <= req0_b;
                            alu_ALUK <= req0_aluk;
                        end
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end

                EXEC: begin
                    // The ALU sees stable registered inputs for this whole
                    // cycle. Its result is captured unchanged.
                    rsp_data  <= alu_result;
                    rsp_nzp   <= calc_nzp(alu_result);
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end

                RESP: begin
                    // Hold everything until the consumer accepts. Both
                    // readies stay low meanwhile because the state is not
                    // IDLE.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed testbench for alu_arbiter.
//
// A small behavioural ALU closes the loop from alu_regA/alu_regB/alu_ALUK
// back to alu_result.
//
// Inputs change on the falling edge. Outputs are sampled on the falling edge,
// or 1 ns after it for the combinational readies.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int W = 16;

    logic         Clk = 1'b0;
    logic         Reset;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [1:0]   req0_aluk;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [1:0]   req1_aluk;

    logic [W-1:0] alu_regA;
    logic [W-1:0] alu_regB;
    logic [1:0]   alu_ALUK;
    logic [W-1:0] alu_result;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic [2:0]   rsp_nzp;
    logic         busy;

    int passed = 0;
    int total  = 0;

    always #5 Clk = ~Clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_aluk  (req0_aluk),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_aluk  (req1_aluk),
        .alu_regA   (alu_regA),
        .alu_regB   (alu_regB),
        .alu_ALUK   (alu_ALUK),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_nzp    (rsp_nzp),
        .busy       (busy)
    );

    // Behavioural model of the external combinational ALU.
    always_comb begin
        case (alu_ALUK)
            2'b00:   alu_result = alu_regA + alu_regB;
            2'b01:   alu_result = alu_regA & alu_regB;
            2'b10:   alu_result = ~alu_regA;
            default: alu_result = alu_regA;
        endcase
    end

    // Global watchdog: the run must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Stimulus helper: send one operation and collect its response.
    //
    // ok = 0 if either the grant or the response does not arrive within
    // 20 cycles.
    // -----------------------------------------------------------------------
    task automatic run_op(input  bit           who,
                          input  logic [W-1:0] a,
                          input  logic [W-1:0] b,
                          input  logic [1:0]   k,
                          output logic         id,
                          output logic [W-1:0] data,
                          output logic [2:0]   nzp,
                          output bit           ok);
        int n;
        ok   = 1'b0;
        id   = 1'b0;
        data = '0;
        nzp  = 3'b000;

        @(negedge Clk);
        if (who) begin
            req1_valid = 1'b1;
            req1_a     = a;
            req1_b     = b;
            req1_aluk  = k;
        end else begin
            req0_valid = 1'b1;
            req0_a     = a;
            req0_b     = b;
            req0_aluk  = k;
        end
        #1;

        // Wait for the grant.
        n = 0;
        while (!(who ? req1_ready : req0_ready) && n < 20) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end

        // Transfer happens on this posedge; withdraw the request afterwards.
        @(posedge Clk);
        @(negedge Clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Wait for the response.
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!rsp_valid) begin
            return;
        end

        id   = rsp_id;
        data = rsp_data;
        nzp  = rsp_nzp;
        ok   = 1'b1;

        // Accept the response.
        rsp_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        rsp_ready = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // test_reset: Reset held high with both requesters valid.
    // -----------------------------------------------------------------------
    task automatic test_reset();
        Reset      = 1'b1;
        req0_valid = 1'b1;
        req0_a     = 16'h1111;
        req0_b     = 16'h2222;
        req0_aluk  = 2'b01;
        req1_valid = 1'b1;
        req1_a     = 16'h3333;
        req1_b     = 16'h4444;
        req1_aluk  = 2'b10;
        rsp_ready  = 1'b0;

        @(negedge Clk);
        @(negedge Clk);
        #1;

        total++;
        if (req0_ready !== 1'b0) $display("FAIL reset_req0_ready: got %b expected 0", req0_ready);
        else passed++;

        total++;
        if (req1_ready !== 1'b0) $display("FAIL reset_req1_ready: got %b expected 0", req1_ready);
        else passed++;

        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else passed++;

        total++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        else passed++;

        total++;
        if (alu_ALUK !== 2'b00) $display("FAIL reset_alu_ALUK: got %b expected 00", alu_ALUK);
        else passed++;

        total++;
        if (rsp_nzp !== 3'b010) $display("FAIL reset_rsp_nzp: got %b expected 010", rsp_nzp);
        else passed++;

        total++;
        if (alu_regA !== 16'h0000 || alu_regB !== 16'h0000)
            $display("FAIL reset_alu_regs: got A=%h B=%h expected 0000 0000", alu_regA, alu_regB);
        else passed++;

        total++;
        if (rsp_data !== 16'h0000 || rsp_id !== 1'b0)
            $display("FAIL reset_rsp: got data=%h id=%b expected 0000 0", rsp_data, rsp_id);
        else passed++;

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        Reset      = 1'b0;
        @(negedge Clk);
    endtask

    // -----------------------------------------------------------------------
    // test_add_latency: req0 ADD 0x7FFF + 0x0001, checked cycle by cycle.
    // -----------------------------------------------------------------------
    task automatic test_add_latency();
        // Cycle 0: request is granted immediately.
        req0_valid = 1'b1;
        req0_a     = 16'h7FFF;
        req0_b     = 16'h0001;
        req0_aluk  = 2'b00;
        #1;

        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL add_ready_c0: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        else passed++;

        // Cycle 1: EXEC.
        @(negedge Clk);
        req0_valid = 1'b0;

        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL add_exec_c1: got rsp_valid=%b busy=%b expected 0 1", rsp_valid, busy);
        else passed++;

        total++;
        if (alu_regA !== 16'h7FFF || alu_regB !== 16'h0001 || alu_ALUK !== 2'b00)
            $display("FAIL add_alu_regs: got %h %h %b expected 7fff 0001 00",
                     alu_regA, alu_regB, alu_ALUK);
        else passed++;

        // Cycle 2: RESP.
        @(negedge Clk);

        total++;
        if (rsp_valid !== 1'b1) $display("FAIL add_rsp_valid_c2: got %b expected 1", rsp_valid);
        else passed++;

        total++;
        if (rsp_id !== 1'b0 || rsp_data !== 16'h8000 || rsp_nzp !== 3'b100)
            $display("FAIL add_rsp: got id=%b data=%h nzp=%b expected 0 8000 100",
                     rsp_id, rsp_data, rsp_nzp);
        else passed++;

        // Accept the response; it must drop the following cycle.
        rsp_ready = 1'b1;
        @(negedge Clk);
        rsp_ready = 1'b0;

        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL add_rsp_drop: got rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        else passed++;
    endtask

    // -----------------------------------------------------------------------
    // test_logic_ops: req1 AND, NOT and PASS.
    // -----------------------------------------------------------------------
    task automatic test_logic_ops();
        logic [W-1:0] a_t [3];
        logic [W-1:0] b_t [3];
        logic [1:0]   k_t [3];
        logic [W-1:0] d_t [3];
        logic [2:0]   z_t [3];
        logic         id;
        logic [W-1:0] data;
        logic [2:0]   nzp;
        bit           ok;

        a_t[0] = 16'h0F0F; b_t[0] = 16'hF0F0; k_t[0] = 2'b01; d_t[0] = 16'h0000; z_t[0] = 3'b010;
        a_t[1] = 16'h0000; b_t[1] = 16'h1234; k_t[1] = 2'b10; d_t[1] = 16'hFFFF; z_t[1] = 3'b100;
        a_t[2] = 16'h0005; b_t[2] = 16'hABCD; k_t[2] = 2'b11; d_t[2] = 16'h0005; z_t[2] = 3'b001;

        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, a_t[i], b_t[i], k_t[i], id, data, nzp, ok);

            total++;
            if (!ok || id !== 1'b1 || data !== d_t[i] || nzp !== z_t[i])
                $display("FAIL logic_op%0d: got ok=%0d id=%b data=%h nzp=%b expected 1 1 %h %b",
                         i, ok, id, data, nzp, d_t[i], z_t[i]);
            else passed++;
        end
    endtask

    // -----------------------------------------------------------------------
    // test_back_to_back: both requesters continuously valid, 6 operations.
    // Grants and responses must alternate 0,1,0,1,0,1.
    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        bit order [6];
        int ng;
        int nr;
        int cyc;

        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;

        req0_valid = 1'b1;
        req0_a     = 16'h0001;
        req0_b     = 16'h0002;
        req0_aluk  = 2'b00;
        req1_valid = 1'b1;
        req1_a     = 16'h0010;
        req1_b     = 16'h0020;
        req1_aluk  = 2'b00;
        rsp_ready  = 1'b1;

        ng  = 0;
        nr  = 0;
        cyc = 0;
        while (nr < 6 && cyc < 60) begin
            #1;
            if (req0_ready && ng < 6) begin
                order[ng] = 1'b0;
                ng++;
            end else if (req1_ready && ng < 6) begin
                order[ng] = 1'b1;
                ng++;
            end

            if (rsp_valid) begin
                total++;
                if (rsp_id !== nr[0])
                    $display("FAIL b2b_rsp_id%0d: got %b expected %b", nr, rsp_id, nr[0]);
                else passed++;

                total++;
                if (rsp_data !== (nr[0] ? 16'h0030 : 16'h0003))
                    $display("FAIL b2b_rsp_data%0d: got %h expected %h",
                             nr, rsp_data, (nr[0] ? 16'h0030 : 16'h0003));
                else passed++;

                nr++;
            end

            if (nr < 6) begin
                @(negedge Clk);
                cyc++;
            end
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge Clk);
        rsp_ready = 1'b0;

        total++;
        if (ng != 6 || nr != 6)
            $display("FAIL b2b_count: got grants=%0d responses=%0d expected 6 6", ng, nr);
        else passed++;

        for (int i = 0; i < 6; i++) begin
            total++;
            if (order[i] !== i[0])
                $display("FAIL b2b_grant%0d: got %b expected %b", i, order[i], i[0]);
            else passed++;
        end
    endtask

    // -----------------------------------------------------------------------
    // test_stall: rsp_ready held low in RESP while req0 keeps requesting.
    // -----------------------------------------------------------------------
    task automatic test_stall();
        // First operation: ADD 0x1234 + 0x0001.
        @(negedge Clk);
        req0_valid = 1'b1;
        req0_a     = 16'h1234;
        req0_b     = 16'h0001;
        req0_aluk  = 2'b00;
        #1;

        total++;
        if (req0_ready !== 1'b1) $display("FAIL stall_first_ready: got %b expected 1", req0_ready);
        else passed++;

        // EXEC: req0 stays valid with a new operation, AND 0x00FF & 0x0F0F.
        @(negedge Clk);
        req0_a    = 16'h00FF;
        req0_b    = 16'h0F0F;
        req0_aluk = 2'b01;
        #1;

        total++;
        if (req0_ready !== 1'b0) $display("FAIL stall_exec_ready: got %b expected 0", req0_ready);
        else passed++;

        // RESP: hold off the consumer for 5 cycles.
        @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            #1;

            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h1235 ||
                rsp_nzp !== 3'b001 || req0_ready !== 1'b0)
                $display("FAIL stall_hold%0d: got v=%b data=%h nzp=%b r0=%b expected 1 1235 001 0",
                         i, rsp_valid, rsp_data, rsp_nzp, req0_ready);
            else passed++;

            @(negedge Clk);
        end

        // Release the response; back to IDLE, where req0 is accepted.
        rsp_ready = 1'b1;
        @(negedge Clk);
        rsp_ready = 1'b0;
        #1;

        total++;
        if (rsp_valid !== 1'b0 || req0_ready !== 1'b1)
            $display("FAIL stall_release: got v=%b r0=%b expected 0 1", rsp_valid, req0_ready);
        else passed++;

        @(negedge Clk);
        req0_valid = 1'b0;
        @(negedge Clk);

        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h000F ||
            rsp_nzp !== 3'b001 || rsp_id !== 1'b0)
            $display("FAIL stall_second: got v=%b data=%h nzp=%b id=%b expected 1 000f 001 0",
                     rsp_valid, rsp_data, rsp_nzp, rsp_id);
        else passed++;

        rsp_ready = 1'b1;
        @(negedge Clk);
        rsp_ready = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    // test_wrap_reset: ADD wrap, Reset during EXEC, then the post-reset tie.
    // -----------------------------------------------------------------------
    task automatic test_wrap_reset();
        logic         id;
        logic [W-1:0] data;
        logic [2:0]   nzp;
        bit           ok;
        bit           seen;

        // ADD 0xFFFF + 0x0001 wraps to zero.
        run_op(1'b1, 16'hFFFF, 16'h0001, 2'b00, id, data, nzp, ok);

        total++;
        if (!ok || id !== 1'b1 || data !== 16'h0000 || nzp !== 3'b010)
            $display("FAIL wrap_add: got ok=%0d id=%b data=%h nzp=%b expected 1 1 0000 010",
                     ok, id, data, nzp);
        else passed++;

        // Start a req0 operation and kill it in EXEC.
        @(negedge Clk);
        req0_valid = 1'b1;
        req0_a     = 16'h0004;
        req0_b     = 16'h0005;
        req0_aluk  = 2'b00;
        #1;

        total++;
        if (req0_ready !== 1'b1) $display("FAIL rst_exec_grant: got %b expected 1", req0_ready);
        else passed++;

        @(negedge Clk);
        req0_valid = 1'b0;

        total++;
        if (busy !== 1'b1) $display("FAIL rst_exec_busy: got %b expected 1", busy);
        else passed++;

        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;

        total++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_nzp !== 3'b010 || rsp_data !== 16'h0000)
            $display("FAIL rst_exec_state: got busy=%b v=%b nzp=%b data=%h expected 0 0 010 0000",
                     busy, rsp_valid, rsp_nzp, rsp_data);
        else passed++;

        // The discarded operation must never produce a response.
        seen = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            if (rsp_valid) seen = 1'b1;
        end

        total++;
        if (seen !== 1'b0) $display("FAIL rst_exec_no_rsp: got %b expected 0", seen);
        else passed++;

        // After reset a tie goes to requester 0. Inputs are withdrawn before
        // the next rising edge, so no transfer takes place.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;

        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL rst_tie: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        else passed++;

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_logic_ops();
        test_back_to_back();
        test_stall();
        test_wrap_reset();
        test_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
